// File: rtl/serial_disp_rx.sv
// serial_disp_rx
// Receives the three-wire serial display stream (shift clock, data, latch
// enable) by oversampling it on clk. Each frame is deserialized MSB first.
// The committed word is presented on data, with a one-cycle valid strobe.
//
// Ports:
//   clk       sampling clock (at least 4x ser_clk)
//   rstn      asynchronous active-low reset
//   ser_clk   serial shift clock; data is sampled on its rising edge
//   ser_do    serial data, MSB first
//   ser_le    latch enable; low while shifting, rising edge commits
//   data      last committed frame
//   valid     one-cycle pulse when data updates
//   frame_err sticky; set by a frame whose bit count differs from FRAME_BITS
//   busy      high while a frame is being received
//
// Build option:
//   SERIAL_DISP_RX_STRICT_EN
//     When defined, frames with a bad length are dropped (no data update,
//     no valid). When undefined, every latch commits the shift register.
//
// state    | meaning
// ST_IDLE  | no frame in progress, bit counter at 0
// ST_SHIFT | frame being shifted in
// ST_LATCH | one cycle: commit frame, clear counter
module serial_disp_rx #(
  parameter int FRAME_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ser_clk,
  input  logic                  ser_do,
  input  logic                  ser_le,
  output logic [FRAME_BITS-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  state_t r_state, w_next;

  // Bits [1:0] form the synchronizer; bit [2] is the edge-detect register.
  logic [2:0] r_clk_sync, r_do_sync, r_le_sync;

  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_valid;
  logic                  r_frame_err;

  logic w_clk_rise, w_le_rise, w_shift, w_do, w_len_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_sync <= '0;
      r_do_sync  <= '0;
      r_le_sync  <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ser_clk};
      r_do_sync  <= {r_do_sync[1:0], ser_do};
      r_le_sync  <= {r_le_sync[1:0], ser_le};
    end
  end

  assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_le_rise  = r_le_sync[1] & ~r_le_sync[2];
  // A shift coinciding with the latch rising edge is still accepted.
  // Only edges where ser_le has already been high for a cycle are dropped.
  assign w_shift    = w_clk_rise & ~(r_le_sync[1] & r_le_sync[2]);
  // The oldest data sample was taken just before ser_clk rose. It lies
  // inside the guaranteed setup window.
  assign w_do       = r_do_sync[2];
  assign w_len_ok   = (r_cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_le_rise)    w_next = ST_LATCH;
        else if (w_shift) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_le_rise) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        // A shift detected during the commit cycle opens the next frame.
        if (w_shift) w_next = ST_SHIFT;
        else         w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_shift) r_shift <= {r_shift[FRAME_BITS-2:0], w_do};

      if (r_state == ST_LATCH) begin
        r_cnt <= w_shift ? CW'(1) : '0;
`ifdef SERIAL_DISP_RX_STRICT_EN
        if (w_len_ok) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
`else
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (!w_len_ok) r_frame_err <= 1'b1;
`endif
      end else if (w_shift && r_cnt != CNT_OVER) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/serial_disp_rx.md
# serial_disp_rx

Receiver for the three-wire serial display stream (shift clock, data, latch enable) that the display driver shifts out to the on-board segment/LED shift-register chain. Oversamples the three wires on its own clock, deserializes each frame, and presents the committed parallel word with a one-cycle valid strobe. Used as the board-side model in simulation and as the capture end on the debug daughterboard; one instance per chain (segment chain 64 bits, LED chain 16 bits).

## Interface

- FRAME_BITS, 64, bits per frame; legal range 2..256
- clk  input  1  sampling clock; at least 4× the shift-clock frequency
- rstn  input  1  asynchronous active-low reset
- ser_clk  input  1  serial shift clock, asynchronous to clk; data valid at its rising edge
- ser_do  input  1  serial data, MSB of the frame first
- ser_le  input  1  latch enable; low during shifting, rising edge commits the frame
- data  output  FRAME_BITS  last committed frame
- valid  output  1  one-cycle pulse when data updates
- frame_err  output  1  sticky; set on a frame whose bit count ≠ FRAME_BITS
- busy  output  1  high while a frame is being shifted in

## Operation

- ser_clk, ser_do, ser_le each pass through a 2-flop synchronizer, then a third register for edge detection.
- Rising edge of synchronized ser_clk while synchronized ser_le = 0: shift synchronized ser_do into a FRAME_BITS shift register at bit 0, older bits move up; first bit shifted ends in data[FRAME_BITS-1].
- ser_clk edges while ser_le = 1 are ignored.
- Bit counter width $clog2(FRAME_BITS+2); increments per accepted shift, saturates at FRAME_BITS+1 (overlength marker).
- FSM:
  - IDLE: counter 0, busy 0. First accepted shift → SHIFT.
  - SHIFT: busy 1. ser_le rising edge → LATCH.
  - LATCH: one cycle; commit per Configuration; clear counter; → IDLE.
- ser_le rising edge in IDLE (zero bits) counts as a short frame: goes to LATCH, treated as count 0.
- Shift edge and ser_le rising edge detected in the same clk cycle: the shift is applied first, then LATCH uses the updated count.
- frame_err clears only on reset.
- Async reset mid-frame: all state cleared immediately; partial frame discarded.

## Timing

- Reset values: data = 0, valid = 0, frame_err = 0, busy = 0; FSM in IDLE; shift register and counter 0.
- Input edge → internal action: 3 clk cycles (2 sync + edge register).
- ser_le rising edge → data/valid: valid high in the 4th clk cycle after the ser_le edge (3 to detect, 1 in LATCH, registered outputs); valid high for exactly 1 cycle.
- busy rises in the cycle after the first accepted shift and falls in the cycle valid is asserted.
- ser_clk high and low phases must each last ≥2 clk periods; ser_do must be stable from 2 clk before to 2 clk after ser_clk rising edge.
- Back-to-back frames: a new shift may be detected the cycle after LATCH; no edges are lost.

## Configuration

- SERIAL_DISP_RX_STRICT_EN defined: on a bad count, data is not updated, valid is not pulsed, frame_err is set.
- SERIAL_DISP_RX_STRICT_EN undefined: data always loads the shift register at LATCH and valid pulses; frame_err is still set on a bad count. On short frames the unshifted high bits keep the previous frame's values; on long frames only the last FRAME_BITS bits are kept.

## Test plan

- Reset: hold rstn = 0 then release, no stimulus → data = 0, valid = 0, busy = 0, frame_err = 0 for 100 cycles.
- Normal frame, FRAME_BITS = 64: shift 64'hDEAD_BEEF_0123_4567 MSB first with ser_clk = clk/8, then raise ser_le → one valid pulse 4 cycles after the ser_le edge, data = 64'hDEAD_BEEF_0123_4567, frame_err = 0.
- Short frame: shift 63 bits, then latch → frame_err = 1. STRICT: no valid and data unchanged. Non-STRICT: valid pulses and data[62:0] holds the 63 bits.
- Long frame: shift 65 bits (leading 1, then 64'h0), then latch → frame_err = 1. Non-STRICT: data = 64'h0.
- Back-to-back frames: 16'hA5A5 then 16'h5A5A with FRAME_BITS = 16 and one idle clk between them → two valid pulses with data in that order, busy low only in the gaps.
- Reset mid-frame: drop rstn after 30 bits, release, then send a full frame 64'h1 → busy drops immediately, no valid for the aborted frame, then data = 64'h1 with one valid pulse.
